// File: rtl/puzzle4_pkg.sv
// Shared constants and types for the puzzle4 row packer and solver.
// Holds ASCII codes, packer FSM states and grid sizing defaults.
package puzzle4_pkg;
  localparam int ROW_SIZE     = 139;
  localparam int MODULAR_SIZE = 32;
  localparam int PADDED_SIZE  = 160;

  localparam logic [7:0] CH_ROLL  = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2e;
  localparam logic [7:0] CH_LF    = 8'h0a;
  localparam logic [7:0] CH_CR    = 8'h0d;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    DONE
  } state_t;
endpackage

// File: rtl/puzzle4_bit_shifter.sv
// Word-assembly shift register with bit count.
// flush gives the partial word left-justified; it is zero when empty.
module puzzle4_bit_shifter
  import puzzle4_pkg::*;
#(
  parameter int MODULAR_SIZE = puzzle4_pkg::MODULAR_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    shift,
  input  logic                    bit_in,
  output logic                    full,
  output logic [MODULAR_SIZE-1:0] word,
  output logic [MODULAR_SIZE-1:0] flush
);
  localparam int CW = $clog2(MODULAR_SIZE) + 1;

  logic [MODULAR_SIZE-1:0] acc;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           shamt;

  assign word  = {acc[MODULAR_SIZE-2:0], bit_in};
  assign full  = shift && (cnt == CW'(MODULAR_SIZE - 1));
  // A shift by the full width yields zero, which is the zero-fill word.
  assign shamt = CW'(MODULAR_SIZE) - cnt;
  assign flush = acc << shamt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (shift) begin
      acc <= word;
      cnt <= full ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/puzzle4_row_packer.sv
// Packs the ASCII puzzle stream into padded grid words, MSB first.
// Define PUZZLE4_PACKER_CHECK_EN to add the sticky err format flag.
module puzzle4_row_packer
  import puzzle4_pkg::*;
#(
  parameter int ROW_SIZE     = puzzle4_pkg::ROW_SIZE,
  parameter int MODULAR_SIZE = puzzle4_pkg::MODULAR_SIZE,
  parameter int PADDED_SIZE  = puzzle4_pkg::PADDED_SIZE,
  parameter int ROWCNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [7:0]              in_byte,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [MODULAR_SIZE-1:0] out_data,
  output logic                    out_row_end,
  output logic                    out_done,
  output logic [ROWCNT_WIDTH-1:0] out_rows
`ifdef PUZZLE4_PACKER_CHECK_EN
  ,
  output logic                    err
`endif
);
  localparam int WORDS_PER_ROW = PADDED_SIZE / MODULAR_SIZE;
  localparam int CLW = $clog2(ROW_SIZE + 1);
  localparam int WIW = $clog2(WORDS_PER_ROW + 1);

  state_t           state;
  logic [CLW-1:0]   col;
  logic [WIW-1:0]   word_idx;
  logic             last_flag;
  logic             clr_rows;

  logic             accept, is_lf, is_cr, is_data;
  logic             take, eol, final_word;
  logic [CLW-1:0]   col_nxt;
  logic             sh_full;
  logic [MODULAR_SIZE-1:0] sh_word, sh_flush;
  logic [ROWCNT_WIDTH-1:0] rows_sat;

  assign accept     = in_valid && in_ready && (state == FILL);
  assign is_lf      = (in_byte == CH_LF);
  assign is_cr      = (in_byte == CH_CR);
  assign is_data    = !is_lf && !is_cr;
  // Characters past the row width are dropped, never shifted.
  assign take       = accept && is_data && (col < CLW'(ROW_SIZE));
  assign eol        = accept && (is_lf || in_last);
  assign col_nxt    = col + CLW'(take);
  assign final_word = (word_idx >= WIW'(WORDS_PER_ROW - 1));
  assign rows_sat   = (&out_rows) ? out_rows : out_rows + 1'b1;

  puzzle4_bit_shifter #(
    .MODULAR_SIZE(MODULAR_SIZE)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .clear (state != FILL),
    .shift (take),
    .bit_in(in_byte == CH_ROLL),
    .full  (sh_full),
    .word  (sh_word),
    .flush (sh_flush)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      col         <= '0;
      word_idx    <= '0;
      last_flag   <= 1'b0;
      clr_rows    <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_row_end <= 1'b0;
      out_done    <= 1'b0;
      out_rows    <= '0;
    end else begin
      out_valid   <= 1'b0;
      out_row_end <= 1'b0;
      out_done    <= 1'b0;
      unique case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (clr_rows) begin
              out_rows <= '0;
              clr_rows <= 1'b0;
            end
            col <= col_nxt;
            if (sh_full) begin
              out_valid <= 1'b1;
              out_data  <= sh_word;
              word_idx  <= word_idx + 1'b1;
            end
            if (eol && col_nxt != '0) begin
              state     <= PAD;
              in_ready  <= 1'b0;
              last_flag <= in_last;
            end else if (eol && in_last) begin
              state    <= DONE;
              in_ready <= 1'b0;
            end
          end
        end
        PAD: begin
          out_valid <= 1'b1;
          out_data  <= sh_flush;
          word_idx  <= word_idx + 1'b1;
          if (final_word) begin
            out_row_end <= 1'b1;
            out_rows    <= rows_sat;
            col         <= '0;
            word_idx    <= '0;
            last_flag   <= 1'b0;
            state       <= last_flag ? DONE : FILL;
            in_ready    <= !last_flag;
          end
        end
        DONE: begin
          out_done <= 1'b1;
          clr_rows <= 1'b1;
          state    <= FILL;
          in_ready <= 1'b1;
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef PUZZLE4_PACKER_CHECK_EN
  logic bad_char, too_long, too_short;

  assign bad_char  = accept && is_data &&
                     (in_byte != CH_ROLL) && (in_byte != CH_EMPTY);
  assign too_long  = accept && is_data && (col >= CLW'(ROW_SIZE));
  assign too_short = eol && (col_nxt != '0) &&
                     (col_nxt < CLW'(ROW_SIZE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (bad_char || too_long || too_short) begin
      err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_puzzle4_row_packer.sv
// Scoreboard bench for puzzle4_row_packer: directed rows, queued
// expected words, and a negedge monitor that pops and compares.
module tb_puzzle4_row_packer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_row_end;
  logic        out_done;
  logic [7:0]  out_rows;
`ifdef PUZZLE4_PACKER_CHECK_EN
  logic        err;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        row_end;
    logic [7:0]  rows;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   lo_cnt = 0;
  logic prev_row_end = 1'b0;

  puzzle4_row_packer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_row_end(out_row_end),
    .out_done   (out_done),
    .out_rows   (out_rows)
`ifdef PUZZLE4_PACKER_CHECK_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_word", {31'd0, out_valid}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("word", out_data, e.data);
          chk("row_end", {31'd0, out_row_end}, {31'd0, e.row_end});
          if (e.row_end) chk("rows", {24'd0, out_rows}, {24'd0, e.rows});
        end
      end
      if (out_done) begin
        done_cnt++;
        chk("done_after_row_end", {31'd0, prev_row_end}, 32'd1);
      end
      if (!in_ready) lo_cnt++;
      prev_row_end = out_valid && out_row_end;
    end
  end

  task automatic push(input logic [31:0] d, input logic re,
                      input logic [7:0] rows);
    exp_t e;
    e.data = d;
    e.row_end = re;
    e.rows = rows;
    q.push_back(e);
  endtask

  // Pushes the padding zero words; the last one closes the row.
  task automatic push_zeros(input int n, input logic [7:0] rows);
    for (int i = 0; i < n; i++) push(32'h0, (i == n - 1), rows);
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_rep(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send(b, 1'b0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_rows", {24'd0, out_rows}, 32'd0);
    chk("rst_out_done", {31'd0, out_done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
`ifdef PUZZLE4_PACKER_CHECK_EN
    chk("err_reset", {31'd0, err}, 32'd0);
`endif

    // 140 chars: the extra one is dropped, output matches 139.
    for (int i = 0; i < 4; i++) push(32'hFFFF_FFFF, 1'b0, 8'd0);
    push(32'hFFE0_0000, 1'b1, 8'd1);
    send_rep(8'h40, 139);
`ifdef PUZZLE4_PACKER_CHECK_EN
    chk("err_139", {31'd0, err}, 32'd0);
`endif
    send(8'h40, 1'b0);
`ifdef PUZZLE4_PACKER_CHECK_EN
    chk("err_140", {31'd0, err}, 32'd1);
`endif
    send(8'h0a, 1'b0);
    drain();

    // Exactly 139 chars; PAD holds in_ready low for one cycle.
    lo_cnt = 0;
    for (int i = 0; i < 4; i++) push(32'hFFFF_FFFF, 1'b0, 8'd0);
    push(32'hFFE0_0000, 1'b1, 8'd2);
    send_rep(8'h40, 139);
    send(8'h0a, 1'b0);
    drain();
    chk("ready_low_cycles", lo_cnt, 32'd1);

    // 32 chars: full word in FILL, four zero words in PAD.
    push(32'hFFFF_FFFF, 1'b0, 8'd0);
    push_zeros(4, 8'd3);
    send_rep(8'h40, 32);
    send(8'h0a, 1'b0);
    drain();

    // Blank lines and CRs are skipped.
    push(32'h8000_0000, 1'b0, 8'd0);
    push_zeros(4, 8'd4);
    send(8'h0a, 1'b0);
    send(8'h0d, 1'b0);
    send(8'h0a, 1'b0);
    send(8'h40, 1'b0);
    send(8'h0d, 1'b0);
    send(8'h0a, 1'b0);
    drain();
    chk("rows_after_blank", {24'd0, out_rows}, 32'd4);
    chk("no_done_yet", done_cnt, 32'd0);

    // Final row with in_last on the newline.
    push(32'hA000_0000, 1'b0, 8'd0);
    push_zeros(4, 8'd5);
    send(8'h40, 1'b0);
    send(8'h2e, 1'b0);
    send(8'h40, 1'b0);
    send(8'h0a, 1'b1);
    drain();
    chk("done_pulses", done_cnt, 32'd1);
    chk("rows_hold_after_done", {24'd0, out_rows}, 32'd5);
`ifdef PUZZLE4_PACKER_CHECK_EN
    chk("err_short_rows", {31'd0, err}, 32'd1);
`endif

    // Reset in the middle of a row discards the partial row.
    push(32'hFFFF_FFFF, 1'b0, 8'd0);
    send_rep(8'h40, 50);
    chk("rows_clear_after_done", {24'd0, out_rows}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("queue_empty_at_reset", q.size(), 32'd0);
`ifdef PUZZLE4_PACKER_CHECK_EN
    chk("err_cleared", {31'd0, err}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push(32'h8000_0000, 1'b0, 8'd0);
    push_zeros(4, 8'd1);
    send(8'h40, 1'b0);
    send(8'h0a, 1'b0);
    drain();
    chk("rows_after_reset", {24'd0, out_rows}, 32'd1);
    chk("done_unchanged", done_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
